// File: rtl/fq_pkg.sv
// Shared types, defaults and width helpers for the fetch queue.
package fq_pkg;

    localparam int unsigned FQ_LANES = 2;
    localparam int unsigned FQ_DEPTH = 8;
    localparam int unsigned FQ_IW    = 16;
    localparam int unsigned FQ_AW    = 9;

    // Entry layout at the default widths; the queue uses the same {ir, pc} order at any width.
    typedef struct packed {
        logic [FQ_IW-1:0] ir;
        logic [FQ_AW-1:0] pc;
    } fq_entry_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned off_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int unsigned icnt_w(input int unsigned lanes);
        return $clog2(lanes) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fq_window.sv
// Combinational read of LANES consecutive entries starting at head, wrapping modulo DEPTH.
module fq_window
    import fq_pkg::*;
#(
    parameter int unsigned LANES = FQ_LANES,
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned W     = FQ_IW + FQ_AW
) (
    input  logic [DEPTH*W-1:0]       entries,
    input  logic [ptr_w(DEPTH)-1:0]  head,
    output logic [LANES*W-1:0]       window
);

    always_comb begin
        window = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            window[i*W +: W] = entries[((32'(head) + i) % DEPTH)*W +: W];
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Multi-issue instruction fetch queue (circular buffer, in-order retire, flush on redirect).
// Optional same-cycle bypass into an empty queue: define FQ_BYPASS_EN.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int unsigned LANES = FQ_LANES,
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned IW    = FQ_IW,
    parameter int unsigned AW    = FQ_AW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [AW-1:0]              fetch_pc,
    input  logic [off_w(LANES)-1:0]    fetch_offset,
    input  logic [LANES*IW-1:0]        fetch_ir,
    output logic [LANES-1:0]           issue_valid,
    output logic [LANES*IW-1:0]        issue_ir,
    output logic [LANES*AW-1:0]        issue_pc,
    input  logic [icnt_w(LANES)-1:0]   issue_count,
    output logic [cnt_w(DEPTH)-1:0]    occupancy
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned OW = off_w(LANES);
    localparam int unsigned W  = IW + AW;

    typedef struct packed {
        logic [IW-1:0] ir;
        logic [AW-1:0] pc;
    } entry_t;

    if (!is_pow2(LANES)) begin : g_bad_lanes
        $error("fetch_queue: LANES must be a power of two");
    end
    if (!is_pow2(DEPTH) || DEPTH < 2*LANES) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two and at least 2*LANES");
    end

    logic [PW-1:0]        head, tail;
    logic [CW-1:0]        occ;
    logic [W-1:0]         mem [DEPTH];
    logic [DEPTH*W-1:0]   mem_flat;
    logic [LANES*W-1:0]   bundle, q_win, issue_win;
    logic [OW-1:0]        eff_off;
    logic                 push;
    logic [CW-1:0]        pushed, avail, consumed, ic_ext;
    logic [PW-1:0]        wr_idx [LANES];

    assign fetch_ready = (occ <= CW'(DEPTH - LANES));
    assign eff_off     = (LANES > 1) ? fetch_offset : '0;
    assign push        = fetch_valid & fetch_ready & ~flush & ~rst;
    assign pushed      = push ? (CW'(LANES) - CW'(eff_off)) : '0;
    assign ic_ext      = CW'(issue_count);
    assign occupancy   = occ;

    always_comb begin
        bundle = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            bundle[i*W +: W] = entry_t'{ir: fetch_ir[i*IW +: IW], pc: fetch_pc + AW'(i)};
            wr_idx[i]        = tail + PW'(i) - PW'(eff_off);
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_flat[i*W +: W] = mem[i];
        end
    end

    fq_window #(.LANES(LANES), .DEPTH(DEPTH), .W(W)) u_win (
        .entries (mem_flat),
        .head    (head),
        .window  (q_win)
    );

`ifdef FQ_BYPASS_EN
    logic                 bypass;
    logic [LANES*W-1:0]   b_win;

    assign bypass = push && (occ == '0);

    // The bundle itself viewed as a LANES-deep ring: starting at the offset lines up the first valid lane.
    fq_window #(.LANES(LANES), .DEPTH(LANES), .W(W)) u_byp (
        .entries (bundle),
        .head    (eff_off),
        .window  (b_win)
    );

    assign avail     = bypass ? pushed : occ;
    assign issue_win = bypass ? b_win : q_win;
`else
    assign avail     = occ;
    assign issue_win = q_win;
`endif

    assign consumed = (ic_ext < avail) ? ic_ext : avail;

    always_comb begin
        issue_valid = '0;
        issue_ir    = '0;
        issue_pc    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            issue_valid[i]        = (avail > CW'(i));
            issue_ir[i*IW +: IW]  = issue_win[i*W + AW +: IW];
            issue_pc[i*AW +: AW]  = issue_win[i*W +: AW];
        end
    end

    // Bypassed lanes are still written; head skips over the ones consumed in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            head <= head + PW'(consumed);
            tail <= tail + PW'(pushed);
            occ  <= occ + pushed - consumed;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (i >= 32'(eff_off)) begin
                    mem[wr_idx[i]] <= bundle[i*W +: W];
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table plus scoreboarded fill/wrap sequence.
module tb_fetch_queue;
    import fq_pkg::*;

    localparam int unsigned LANES = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned IW    = 16;
    localparam int unsigned AW    = 9;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic                 fetch_valid;
    logic                 fetch_ready;
    logic [AW-1:0]        fetch_pc;
    logic [0:0]           fetch_offset;
    logic [LANES*IW-1:0]  fetch_ir;
    logic [LANES-1:0]     issue_valid;
    logic [LANES*IW-1:0]  issue_ir;
    logic [LANES*AW-1:0]  issue_pc;
    logic [1:0]           issue_count;
    logic [3:0]           occupancy;

    fetch_queue #(.LANES(LANES), .DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_pc     (fetch_pc),
        .fetch_offset (fetch_offset),
        .fetch_ir     (fetch_ir),
        .issue_valid  (issue_valid),
        .issue_ir     (issue_ir),
        .issue_pc     (issue_pc),
        .issue_count  (issue_count),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass;
    int unsigned n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle();
        flush        = 1'b0;
        fetch_valid  = 1'b0;
        fetch_pc     = '0;
        fetch_offset = '0;
        fetch_ir     = '0;
        issue_count  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    typedef struct {
        logic            flush;
        logic            fv;
        logic [AW-1:0]   pc;
        logic            off;
        logic [IW-1:0]   ir1;
        logic [IW-1:0]   ir0;
        logic [1:0]      ic;
        int unsigned     occ;
        logic [1:0]      valid;
        logic            ready;
        logic [IW-1:0]   e_ir0;
        logic [AW-1:0]   e_pc0;
        logic [IW-1:0]   e_ir1;
        logic [AW-1:0]   e_pc1;
    } vec_t;

    vec_t vecs [7];

    fq_entry_t   model [$];
    int unsigned bnum;

    task automatic model_cycle(input logic fv, input int unsigned ic, input string tag);
        int unsigned n;
        bit ready_m;
        fq_entry_t e;
        ready_m      = (DEPTH - model.size()) >= LANES;
        fetch_valid  = fv;
        fetch_pc     = AW'(9'h100 + 2*bnum);
        fetch_offset = 1'b0;
        fetch_ir     = {IW'(16'h1001 + 2*bnum), IW'(16'h1000 + 2*bnum)};
        issue_count  = 2'(ic);
        n = (ic < model.size()) ? ic : model.size();
        for (int unsigned k = 0; k < n; k++) void'(model.pop_front());
        if (fv && ready_m) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                e.ir = fetch_ir[l*IW +: IW];
                e.pc = fetch_pc + AW'(l);
                model.push_back(e);
            end
            bnum++;
        end
        step();
        check({tag, " occupancy"}, 32'(occupancy), model.size());
        check({tag, " fetch_ready"}, 32'(fetch_ready), 32'((DEPTH - model.size()) >= LANES));
        check({tag, " issue_valid"}, 32'(issue_valid),
              32'((model.size() >= 2) ? 2'b11 : (model.size() == 1) ? 2'b01 : 2'b00));
        if (model.size() >= 1) begin
            check({tag, " lane0 ir"}, 32'(issue_ir[0 +: IW]), 32'(model[0].ir));
            check({tag, " lane0 pc"}, 32'(issue_pc[0 +: AW]), 32'(model[0].pc));
        end
        if (model.size() >= 2) begin
            check({tag, " lane1 ir"}, 32'(issue_ir[IW +: IW]), 32'(model[1].ir));
            check({tag, " lane1 pc"}, 32'(issue_pc[AW +: AW]), 32'(model[1].pc));
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        bnum    = 0;
        idle();
        rst = 1'b1;

        //        flush fv  pc      off ir1       ir0       ic  occ valid ready e_ir0     e_pc0   e_ir1     e_pc1
        vecs[0] = '{1'b0, 1'b1, 9'h010, 1'b0, 16'hA002, 16'hA001, 2'd0, 2, 2'b11, 1'b1, 16'hA001, 9'h010, 16'hA002, 9'h011};
        vecs[1] = '{1'b0, 1'b1, 9'h012, 1'b0, 16'hA004, 16'hA003, 2'd0, 4, 2'b11, 1'b1, 16'hA001, 9'h010, 16'hA002, 9'h011};
        vecs[2] = '{1'b0, 1'b0, 9'h000, 1'b0, 16'h0000, 16'h0000, 2'd1, 3, 2'b11, 1'b1, 16'hA002, 9'h011, 16'hA003, 9'h012};
        vecs[3] = '{1'b0, 1'b1, 9'h014, 1'b0, 16'hA006, 16'hA005, 2'd2, 3, 2'b11, 1'b1, 16'hA004, 9'h013, 16'hA005, 9'h014};
        vecs[4] = '{1'b1, 1'b1, 9'h016, 1'b0, 16'hA008, 16'hA007, 2'd2, 0, 2'b00, 1'b1, 16'h0000, 9'h000, 16'h0000, 9'h000};
        vecs[5] = '{1'b0, 1'b1, 9'h020, 1'b1, 16'hB002, 16'hB001, 2'd0, 1, 2'b01, 1'b1, 16'hB002, 9'h021, 16'h0000, 9'h000};
        vecs[6] = '{1'b0, 1'b1, 9'h030, 1'b0, 16'hC002, 16'hC001, 2'd2, 2, 2'b11, 1'b1, 16'hC001, 9'h030, 16'hC002, 9'h031};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset occupancy", 32'(occupancy), 0);
        check("reset issue_valid", 32'(issue_valid), 0);
        check("reset fetch_ready", 32'(fetch_ready), 1);

        for (int unsigned v = 0; v < 7; v++) begin
            flush        = vecs[v].flush;
            fetch_valid  = vecs[v].fv;
            fetch_pc     = vecs[v].pc;
            fetch_offset = vecs[v].off;
            fetch_ir     = {vecs[v].ir1, vecs[v].ir0};
            issue_count  = vecs[v].ic;
            step();
            check($sformatf("vec%0d occupancy", v), 32'(occupancy), vecs[v].occ);
            check($sformatf("vec%0d issue_valid", v), 32'(issue_valid), 32'(vecs[v].valid));
            check($sformatf("vec%0d fetch_ready", v), 32'(fetch_ready), 32'(vecs[v].ready));
            if (vecs[v].valid[0]) begin
                check($sformatf("vec%0d lane0 ir", v), 32'(issue_ir[0 +: IW]), 32'(vecs[v].e_ir0));
                check($sformatf("vec%0d lane0 pc", v), 32'(issue_pc[0 +: AW]), 32'(vecs[v].e_pc0));
            end
            if (vecs[v].valid[1]) begin
                check($sformatf("vec%0d lane1 ir", v), 32'(issue_ir[IW +: IW]), 32'(vecs[v].e_ir1));
                check($sformatf("vec%0d lane1 pc", v), 32'(issue_pc[AW +: AW]), 32'(vecs[v].e_pc1));
            end
        end

        // Reset while a push is offered: both the queue and the push must vanish.
        rst          = 1'b1;
        fetch_valid  = 1'b1;
        fetch_pc     = 9'h040;
        fetch_ir     = {16'hD002, 16'hD001};
        issue_count  = 2'd0;
        step();
        rst = 1'b0;
        check("rst+push occupancy", 32'(occupancy), 0);
        check("rst+push issue_valid", 32'(issue_valid), 0);

        model.delete();
        for (int unsigned k = 0; k < 5; k++) model_cycle(1'b1, 0, $sformatf("fill%0d", k));
        model_cycle(1'b1, 2, "full+issue");
        for (int unsigned k = 0; k < 20; k++) model_cycle(1'b1, 2, $sformatf("wrap%0d", k));
        for (int unsigned k = 0; k < 10 && model.size() > 0; k++) model_cycle(1'b0, 2, $sformatf("drain%0d", k));
        check("drained occupancy", 32'(occupancy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
